// File: rtl/riscv_dmem_arbiter.sv
// Core/external data-memory arbiter: combinational grant, external read data returned one cycle after grant.
// Losers see o_c_stall / o_e_ready=0. Define DMEM_ARB_STARVE_EN for starvation-forced external priority.
module riscv_dmem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_c_req,
  input  logic            i_c_wen,
  input  logic [XLEN-1:0] i_c_addr,
  input  logic [XLEN-1:0] i_c_wdata,
  input  logic [3:0]      i_c_byte_sel,
  output logic            o_c_stall,
  output logic [XLEN-1:0] o_c_rdata,
  input  logic            i_e_valid,
  input  logic            i_e_wen,
  input  logic [XLEN-1:0] i_e_addr,
  input  logic [XLEN-1:0] i_e_wdata,
  input  logic [3:0]      i_e_byte_sel,
  output logic            o_e_ready,
  output logic            o_e_rvalid,
  output logic [XLEN-1:0] o_e_rdata,
  output logic [XLEN-1:0] o_mem_addr,
  output logic            o_mem_wen,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [3:0]      o_mem_byte_sel,
  input  logic [XLEN-1:0] i_mem_rdata
);

  logic            w_ext_pri;
  logic            w_grant_e;
  logic            w_grant_c;
  logic            r_e_rvalid;
  logic [XLEN-1:0] r_e_rdata;

  generate
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
      $error("riscv_dmem_arbiter: STARVE_LIMIT must be in 1..15");
    end
  endgenerate

`ifdef DMEM_ARB_STARVE_EN
  typedef enum logic {
    CORE_PRI = 1'b0,
    EXT_PRI  = 1'b1
  } state_t;

  localparam logic [4:0] LP_LIMIT = 5'(STARVE_LIMIT);

  state_t     r_state;
  logic [3:0] r_starve_cnt;
  logic [4:0] w_cnt_p1;
  logic       w_e_denied;

  assign w_ext_pri  = (r_state == EXT_PRI);
  assign w_e_denied = i_e_valid && !w_grant_e;
  assign w_cnt_p1   = {1'b0, r_starve_cnt} + 5'd1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= CORE_PRI;
      r_starve_cnt <= '0;
    end else begin
      if (!w_e_denied) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != 4'hF) begin
        r_starve_cnt <= w_cnt_p1[3:0];
      end
      // EXT_PRI always grants or sees a withdrawn request, so it lasts exactly one cycle.
      if (r_state == CORE_PRI && w_e_denied && w_cnt_p1 >= LP_LIMIT) begin
        r_state <= EXT_PRI;
      end else begin
        r_state <= CORE_PRI;
      end
    end
  end
`else
  assign w_ext_pri = 1'b0;
`endif

  assign w_grant_e = i_e_valid && (w_ext_pri || !i_c_req);
  assign w_grant_c = i_c_req && !w_grant_e;

  assign o_e_ready = w_grant_e;
  assign o_c_stall = i_c_req && w_grant_e;
  assign o_c_rdata = i_mem_rdata;

  always_comb begin
    o_mem_addr     = '0;
    o_mem_wen      = 1'b0;
    o_mem_wdata    = '0;
    o_mem_byte_sel = '0;
    if (w_grant_e) begin
      o_mem_addr     = i_e_addr;
      o_mem_wen      = i_e_wen;
      o_mem_wdata    = i_e_wdata;
      o_mem_byte_sel = i_e_byte_sel;
    end else if (w_grant_c) begin
      o_mem_addr     = i_c_addr;
      o_mem_wen      = i_c_wen;
      o_mem_wdata    = i_c_wdata;
      o_mem_byte_sel = i_c_byte_sel;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_e_rvalid <= 1'b0;
      r_e_rdata  <= '0;
    end else begin
      r_e_rvalid <= w_grant_e && !i_e_wen;
      if (w_grant_e && !i_e_wen) begin
        r_e_rdata <= i_mem_rdata;
      end
    end
  end

  assign o_e_rvalid = r_e_rvalid;
  assign o_e_rdata  = r_e_rdata;

endmodule

// File: doc/riscv_dmem_arbiter.md
RISCV_DMEM_ARBITER -- requirements
Module: riscv_dmem_arbiter

Interface
REQ-001 Parameter XLEN, default 32: data and address width.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive denied external-request cycles before the external port gets forced priority (range 1..15).
REQ-003 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_c_req  in  1  core MEM-stage access request (load or store) this cycle.
REQ-006 i_c_wen, i_c_addr, i_c_wdata, i_c_byte_sel  in  1/XLEN/XLEN/4  core write enable, byte address, store data, byte lanes.
REQ-007 o_c_stall  out  1  core request not granted this cycle; core must hold MEM stage and re-present the request.
REQ-008 o_c_rdata  out  XLEN  read data for the core (i_mem_rdata passed through).
REQ-009 i_e_valid, i_e_wen, i_e_addr, i_e_wdata, i_e_byte_sel  in  1/1/XLEN/XLEN/4  external (loader/debug) request, valid/ready.
REQ-010 o_e_ready  out  1  external request accepted this cycle.
REQ-011 o_e_rvalid, o_e_rdata  out  1/XLEN  external read response, registered.
REQ-012 o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_byte_sel  out  XLEN/1/XLEN/4  to the data-memory interface.
REQ-013 i_mem_rdata  in  XLEN  memory read data, valid in the cycle the address is presented (combinational read).

Function
REQ-014 Grant is combinational per cycle; the memory bus SHALL carry exactly one granted master, or all-zero with o_mem_wen=0 when none is granted.
REQ-015 States: CORE_PRI (default) and EXT_PRI.
REQ-016 CORE_PRI: i_c_req=1 grants core (o_c_stall=0, o_e_ready=0); i_c_req=0 and i_e_valid=1 grants external (o_e_ready=1).
REQ-017 EXT_PRI: i_e_valid=1 grants external and asserts o_c_stall if i_c_req=1; the next state is CORE_PRI after that grant.
REQ-018 EXT_PRI with i_e_valid=0 (external request withdrawn) SHALL behave as CORE_PRI that cycle and return to CORE_PRI.
REQ-019 Starve counter (4 bit): increments each cycle with i_e_valid=1 and o_e_ready=0; clears on any external grant or on i_e_valid=0; saturates at 15.
REQ-020 Counter reaching STARVE_LIMIT with external still denied SHALL move the state CORE_PRI->EXT_PRI at the next edge.
REQ-021 Granted external read: o_e_rvalid=1 and o_e_rdata=i_mem_rdata exactly one cycle after grant; otherwise o_e_rvalid=0 and o_e_rdata holds.
REQ-022 Granted external write: no response; o_e_rvalid stays 0.
REQ-023 o_c_rdata SHALL always equal i_mem_rdata; it is meaningful only when the core is granted.
REQ-024 Back-to-back external grants SHALL give one o_e_rvalid per granted read, in order, with no bubble.
REQ-025 o_c_stall SHALL never be asserted when i_c_req=0.

Reset
REQ-026 i_rst=1 SHALL immediately force: state CORE_PRI, counter 0, o_e_rvalid 0, o_e_rdata 0.
REQ-027 Reset mid-operation SHALL drop any pending read response; no o_e_rvalid after reset release for pre-reset grants.
REQ-028 Combinational outputs follow REQ-016 during reset (CORE_PRI behaviour).

Configuration
REQ-029 Macro DMEM_ARB_STARVE_EN defined: starve counter and EXT_PRI state present per REQ-017..020.
REQ-030 Macro DMEM_ARB_STARVE_EN undefined: strict core priority; counter and EXT_PRI absent; external is granted only when i_c_req=0; STARVE_LIMIT is ignored.

Verification
REQ-031 Core load addr 0x100, no external -> o_mem_addr=0x100, o_c_stall=0, o_c_rdata=memory word, o_e_ready=0.
REQ-032 Core idle, external read 0x200 (mem=0xDEADBEEF) -> o_e_ready=1 that cycle; o_e_rvalid=1 with o_e_rdata=0xDEADBEEF next cycle.
REQ-033 STARVE_EN, STARVE_LIMIT=4, core requests every cycle, external valid from cycle 0 -> external denied cycles 0-3, granted cycle 4 with o_c_stall=1; core granted cycle 5.
REQ-034 STARVE_EN undefined, same stimulus for 20 cycles -> o_e_ready=0 throughout, o_c_stall=0 throughout.
REQ-035 External write 0x300 data 0x12345678 byte_sel 4'b0011 while core idle -> o_mem_wen=1, o_mem_byte_sel=4'b0011; no o_e_rvalid; core read of 0x300 returns lower half 0x5678.
REQ-036 External read granted, i_rst pulsed before next edge -> o_e_rvalid=0, o_e_rdata=0, counter 0 after release.
